// File: rtl/aes_pkg.sv
// Shared constants and FSM encoding for the AES stream loader.
package aes_pkg;

    localparam int WIDTH             = 128;
    localparam int WORD              = 32;
    localparam int BEATS             = WIDTH / WORD;
    localparam int BUSY_WAIT_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        WAIT_HI,
        WAIT_LO,
        CAPTURE
    } state_t;

endpackage

// File: rtl/aes_word_packer.sv
// Assembles WIDTH/WORD stream words into one block, MSB word first,
// and holds it until the consumer clears the full flag.
module aes_word_packer
    import aes_pkg::*;
#(
    parameter int WIDTH = aes_pkg::WIDTH,
    parameter int WORD  = aes_pkg::WORD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WORD-1:0]  in_data_i,
    input  logic             clr_i,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int NB = WIDTH / WORD;
    localparam int CW = $clog2(NB);

    logic [WIDTH-1:0] word_buf_q, word_buf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             en_q;
    logic             beat;

    // en_q keeps in_ready low while reset is asserted.
    assign in_ready_o = en_q & ~full_q;
    assign beat       = in_valid_i & in_ready_o;
    assign full_o     = full_q;
    assign data_o     = word_buf_q;

    // Next-state: shift a word in on each beat, mark full on the last one.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        word_buf_d = word_buf_q;
        cnt_d      = cnt_q;
        full_d     = full_q & ~clr_i;
        if (beat) begin
            word_buf_d = {word_buf_q[WIDTH-WORD-1:0], in_data_i};
            if (cnt_q == CW'(NB - 1)) begin
                cnt_d  = '0;
                full_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_buf_q <= '0;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            word_buf_q <= word_buf_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            en_q       <= 1'b1;
        end
    end

endmodule

// File: rtl/aes_stream_loader.sv
// Stream adapter around an AES core: packs plaintext words, triggers the
// core, waits for busy to rise and fall, and serialises the result.
module aes_stream_loader
    import aes_pkg::*;
#(
    parameter int WIDTH     = aes_pkg::WIDTH,
    parameter int WORD      = aes_pkg::WORD,
    parameter int BUSY_WAIT = aes_pkg::BUSY_WAIT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WORD-1:0]  in_data,
    input  logic             key_wr,
    input  logic [1:0]       key_idx,
    input  logic [WORD-1:0]  key_wdata,
    output logic             core_trig,
    output logic [WIDTH-1:0] core_data,
    output logic [WIDTH-1:0] core_key,
    input  logic             core_busy,
    input  logic [WIDTH-1:0] core_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WORD-1:0]  out_data,
    output logic             out_last,
    output logic             err
);

    localparam int NB = WIDTH / WORD;
    localparam int CW = $clog2(NB);
    localparam int TW = $clog2(BUSY_WAIT + 1);

    state_t           state_q;
    logic [TW-1:0]    timer_q;
    logic             core_trig_q;
    logic [WIDTH-1:0] core_data_q;
    logic [WIDTH-1:0] core_key_q;
    logic             err_q;

    logic [WIDTH-1:0] out_buf_q;
    logic [CW-1:0]    out_cnt_q;
    logic             out_full_q;
    logic [WORD-1:0]  out_word;

    logic             in_full;
    logic [WIDTH-1:0] in_block;
    logic             fire;
    logic             capture;
    logic             out_hs;

    // Fire only from IDLE with a full input, an empty output and an idle core;
    // all terms are registered, so same-cycle fills or drains wait one cycle.
    assign fire    = (state_q == IDLE) & in_full & ~out_full_q & ~core_busy;
    assign capture = (state_q == CAPTURE);
    assign out_hs  = out_full_q & out_ready;

    aes_word_packer #(
        .WIDTH (WIDTH),
        .WORD  (WORD)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .clr_i      (fire),
        .full_o     (in_full),
        .data_o     (in_block)
    );

    // Control FSM: trigger, busy handshake with timeout, capture, key writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            core_trig_q <= 1'b0;
            core_data_q <= '0;
            core_key_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            core_trig_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Key changes are only accepted while no block is in flight.
                    if (key_wr) begin
                        for (int i = 0; i < NB; i++) begin
                            if (key_idx == 2'(i)) begin
                                core_key_q[(NB-1-i)*WORD +: WORD] <= key_wdata;
                            end
                        end
                    end
                    if (fire) begin
                        core_data_q <= in_block;
                        core_trig_q <= 1'b1;
                        state_q     <= FIRE;
                    end
                end
                FIRE: begin
                    timer_q <= '0;
                    state_q <= WAIT_HI;
                end
                WAIT_HI: begin
                    // The timer counts WAIT_HI cycles without busy; hitting
                    // BUSY_WAIT abandons the block and flags the error.
                    if (core_busy) begin
                        state_q <= WAIT_LO;
                    end else if (timer_q == TW'(BUSY_WAIT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!core_busy) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Output buffer: load on CAPTURE, advance one word per handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_buf_q  <= '0;
            out_cnt_q  <= '0;
            out_full_q <= 1'b0;
        end else if (capture) begin
            out_buf_q  <= core_result;
            out_cnt_q  <= '0;
            out_full_q <= 1'b1;
        end else if (out_hs) begin
            if (out_cnt_q == CW'(NB - 1)) begin
                out_cnt_q  <= '0;
                out_full_q <= 1'b0;
            end else begin
                out_cnt_q <= out_cnt_q + 1'b1;
            end
        end
    end

    // Word select, MSB word first; stable while the counter is held.
    always_comb begin
        out_word = '0;
        for (int i = 0; i < NB; i++) begin
            if (out_cnt_q == CW'(i)) begin
                out_word = out_buf_q[(NB-1-i)*WORD +: WORD];
            end
        end
    end

    assign core_trig = core_trig_q;
    assign core_data = core_data_q;
    assign core_key  = core_key_q;
    assign err       = err_q;
    assign out_valid = out_full_q;
    assign out_data  = out_word;
    assign out_last  = out_full_q & (out_cnt_q == CW'(NB - 1));

endmodule

// File: tb/tb_aes_stream_loader.sv
// Randomised bench for aes_stream_loader with a behavioural core and a
// block-level scoreboard.
module tb_aes_stream_loader;
    import aes_pkg::*;

    localparam int BW       = 4;
    localparam int BUSY_CYC = 20;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         key_wr = 1'b0;
    logic [1:0]   key_idx = '0;
    logic [31:0]  key_wdata = '0;
    logic         core_trig;
    logic [127:0] core_data;
    logic [127:0] core_key;
    logic         core_busy;
    logic [127:0] core_result = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic         out_last;
    logic         err;

    aes_stream_loader #(.WIDTH(WIDTH), .WORD(WORD), .BUSY_WAIT(BW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .key_wr(key_wr), .key_idx(key_idx), .key_wdata(key_wdata),
        .core_trig(core_trig), .core_data(core_data), .core_key(core_key),
        .core_busy(core_busy), .core_result(core_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Stand-in for the AES round function; any data/key-dependent mix will do.
    function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k);
        logic [127:0] x;
        x = d ^ k;
        return {x[119:0], x[127:120]} + {4{32'h9e3779b9}};
    endfunction

    // Bench-side state: stimulus queues, scoreboard, core model, timestamps.
    logic [31:0]  in_q[$];
    logic [127:0] cur_blk = '0;
    int           cur_cnt = 0;
    logic [127:0] exp_blk[$];
    logic [31:0]  exp_out[$];
    logic [127:0] key_model = '0;
    int           cyc = 0;
    int           trig_count = 0;
    int           trig_cycs[$];
    int           last_cycs[$];
    int           last_in_cyc = 0;
    int           out_beat = 0;
    bit           prev_trig = 0;
    bit           alive = 1;
    bit           hold_busy = 0;
    bit           model_busy = 0;
    bit           pending = 0;
    int           rise_left = 0;
    int           busy_left = 0;
    logic [127:0] cd_lat = '0, ck_lat = '0;
    bit           rand_ready = 1;
    bit           stall_req = 0;
    int           stall_left = 0;
    bit           hold_pending = 0;
    logic [31:0]  held_data = '0;

    assign core_busy = model_busy | hold_busy;

    // Trigger monitor plus behavioural core: busy rises 0..2 cycles after the
    // trigger, stays high BUSY_CYC cycles, result appears as busy falls.
    task automatic core_step();
        logic [127:0] blk, res;
        if (core_trig) begin
            check("trig_one_cycle", prev_trig, 1'b0);
            trig_count++;
            trig_cycs.push_back(cyc);
            check("trig_has_block", exp_blk.size() > 0, 1'b1);
            if (exp_blk.size() > 0) begin
                blk = exp_blk.pop_front();
                check("core_data", core_data, blk);
                check("core_key", core_key, key_model);
                if (alive) begin
                    res = core_fn(blk, key_model);
                    for (int i = 3; i >= 0; i--) exp_out.push_back(res[i*32 +: 32]);
                end
            end
            if (alive) begin
                cd_lat      = core_data;
                ck_lat      = core_key;
                core_result = {$urandom, $urandom, $urandom, $urandom};
                rise_left   = $urandom_range(0, 2);
                pending     = 1;
            end
        end
        prev_trig = core_trig;
        if (pending) begin
            if (rise_left == 0) begin
                model_busy = 1;
                busy_left  = BUSY_CYC;
                pending    = 0;
            end else begin
                rise_left--;
            end
        end else if (model_busy) begin
            busy_left--;
            if (busy_left == 0) begin
                model_busy  = 0;
                core_result = core_fn(cd_lat, ck_lat);
            end
        end
    endtask

    // Input driver: random gaps; a word counts when valid and ready meet.
    task automatic drive_in();
        logic [31:0] w;
        in_valid = (in_q.size() > 0) && ($urandom_range(0, 3) != 0);
        in_data  = in_valid ? in_q[0] : $urandom;
        if (in_valid && in_ready) begin
            w       = in_q.pop_front();
            cur_blk = {cur_blk[95:0], w};
            cur_cnt++;
            if (cur_cnt == 4) begin
                exp_blk.push_back(cur_blk);
                cur_cnt     = 0;
                last_in_cyc = cyc;
            end
        end
    endtask

    // Output consumer: random or stalled ready, hold and order checks.
    task automatic drive_out();
        bit rdy;
        if (hold_pending) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", out_data, held_data);
        end
        if (stall_req && out_valid && out_beat == 1 && stall_left == 0) begin
            stall_left = 10;
            stall_req  = 0;
        end
        if (stall_left > 0) begin
            rdy = 0;
            stall_left--;
            check("stall_valid", out_valid, 1'b1);
        end else begin
            rdy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        out_ready    = rdy;
        hold_pending = out_valid && !rdy;
        held_data    = out_data;
        if (out_valid && rdy) begin
            check("out_last", out_last, out_beat == 3);
            check("out_expected", exp_out.size() > 0, 1'b1);
            if (exp_out.size() > 0) check("out_data", out_data, exp_out.pop_front());
            if (out_beat == 3) last_cycs.push_back(cyc);
            out_beat = (out_beat + 1) % 4;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                in_valid  = 0;
                out_ready = 0;
                prev_trig = 0;
            end else begin
                core_step();
                drive_in();
                drive_out();
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send_block(input logic [127:0] b);
        for (int i = 3; i >= 0; i--) in_q.push_back(b[i*32 +: 32]);
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while (!(in_q.size() == 0 && cur_cnt == 0 && exp_blk.size() == 0 &&
                 exp_out.size() == 0 && !model_busy && !pending) && t < 3000) begin
            tick();
            t++;
        end
        check({tag, "_drain_in_time"}, t < 3000, 1'b1);
        tick(2);
    endtask

    task automatic wait_busy(input string tag);
        int t = 0;
        while (!model_busy && t < 200) begin
            tick();
            t++;
        end
        check({tag, "_busy_in_time"}, t < 200, 1'b1);
    endtask

    task automatic key_write(input logic [1:0] idx, input logic [31:0] v);
        key_wr    = 1;
        key_idx   = idx;
        key_wdata = v;
        tick();
        key_wr = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_core_trig"}, core_trig, 1'b0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_last"}, out_last, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_core_data"}, core_data, '0);
        check({tag, "_core_key"}, core_key, '0);
        check({tag, "_out_data"}, out_data, '0);
    endtask

    initial begin
        logic [127:0] kinit;
        int n0, ta, la, t;
        kinit = {32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};

        // Reset state.
        #12;
        check_all_zero("rst");
        @(negedge clk);
        #1;
        reset = 1;
        tick();
        check("ready_after_reset", in_ready, 1'b1);

        // Key load in IDLE.
        for (int i = 0; i < 4; i++) key_write(2'(i), kinit[(3-i)*32 +: 32]);
        key_model = kinit;
        check("key_loaded", core_key, key_model);

        // Single block: two-cycle trigger latency, one pulse.
        n0 = trig_count;
        ta = trig_cycs.size();
        send_block({32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734});
        wait_drain("t1");
        check("t1_one_trig", trig_count - n0, 1);
        if (trig_cycs.size() > ta) check("t1_trig_latency", trig_cycs[ta] - last_in_cyc, 2);

        // Double buffering: B loads while A is busy, fires 2 cycles after A drains.
        n0 = trig_count;
        ta = trig_cycs.size();
        la = last_cycs.size();
        send_block({$urandom, $urandom, $urandom, $urandom});
        wait_busy("t2");
        send_block({$urandom, $urandom, $urandom, $urandom});
        t = 0;
        while ((in_q.size() != 0 || cur_cnt != 0) && t < 200) begin
            tick();
            t++;
        end
        tick();
        check("t2_ready_drop", in_ready, 1'b0);
        check("t2_b_not_fired", trig_count - n0, 1);
        wait_drain("t2");
        check("t2_two_trigs", trig_count - n0, 2);
        if (trig_cycs.size() > ta + 1 && last_cycs.size() > la)
            check("t2_b_fire_delay", trig_cycs[ta+1] - last_cycs[la], 2);

        // Output stall on beat 2 with a second block waiting.
        stall_req = 1;
        send_block({$urandom, $urandom, $urandom, $urandom});
        wait_busy("t3");
        send_block({$urandom, $urandom, $urandom, $urandom});
        t = 0;
        while (stall_left == 0 && t < 300) begin
            tick();
            t++;
        end
        check("t3_stall_seen", t < 300, 1'b1);
        n0 = trig_count;
        t = 0;
        while (stall_left > 0 && t < 50) begin
            tick();
            t++;
        end
        check("t3_no_trig_in_stall", trig_count, n0);
        wait_drain("t3");

        // Dead core: err rises BUSY_WAIT cycles after the trigger pulse ends.
        alive = 0;
        n0 = trig_count;
        send_block({$urandom, $urandom, $urandom, $urandom});
        t = 0;
        while (trig_count == n0 && t < 200) begin
            tick();
            t++;
        end
        check("t4_trig_seen", trig_count - n0, 1);
        check("t4_err_before", err, 1'b0);
        t = 0;
        while (!err && t < 50) begin
            tick();
            t++;
        end
        if (trig_cycs.size() > 0) check("t4_err_delay", cyc - trig_cycs[trig_cycs.size()-1], BW + 1);
        check("t4_err_set", err, 1'b1);
        alive = 1;
        send_block({$urandom, $urandom, $urandom, $urandom});
        wait_drain("t4");
        check("t4_recovered_trigs", trig_count - n0, 2);
        check("t4_err_sticky", err, 1'b1);

        // Key write dropped in WAIT_LO, accepted in IDLE.
        send_block({$urandom, $urandom, $urandom, $urandom});
        wait_busy("t5");
        tick(2);
        key_write(2'd1, 32'hdeadbeef);
        check("t5_key_dropped", core_key, key_model);
        wait_drain("t5a");
        key_write(2'd1, 32'h0badf00d);
        key_model[95:64] = 32'h0badf00d;
        check("t5_key_word1", core_key[95:64], 32'h0badf00d);
        check("t5_key_rest", core_key, key_model);
        send_block({$urandom, $urandom, $urandom, $urandom});
        wait_drain("t5b");

        // Core busy already high in IDLE blocks firing.
        hold_busy = 1;
        n0 = trig_count;
        send_block({$urandom, $urandom, $urandom, $urandom});
        t = 0;
        while ((in_q.size() != 0 || cur_cnt != 0) && t < 200) begin
            tick();
            t++;
        end
        tick(8);
        check("t6_no_fire_busy", trig_count, n0);
        hold_busy = 0;
        wait_drain("t6");
        check("t6_fire_after_drop", trig_count - n0, 1);

        // Asynchronous reset mid-WAIT_LO.
        send_block({$urandom, $urandom, $urandom, $urandom});
        wait_busy("t7");
        tick(3);
        #2;
        reset = 0;
        #1;
        check_all_zero("t7_rst");
        in_q.delete();
        exp_blk.delete();
        exp_out.delete();
        cur_cnt = 0;
        model_busy = 0;
        pending = 0;
        out_beat = 0;
        hold_pending = 0;
        stall_left = 0;
        key_model = '0;
        tick(2);
        reset = 1;
        tick();
        n0 = trig_count;
        send_block({$urandom, $urandom, $urandom, $urandom});
        wait_drain("t7");
        check("t7_after_reset_trig", trig_count - n0, 1);

        // Random traffic with occasional key changes between blocks.
        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                logic [1:0]  ki;
                logic [31:0] kv;
                ki = 2'($urandom_range(0, 3));
                kv = $urandom;
                key_write(ki, kv);
                key_model[(3-int'(ki))*32 +: 32] = kv;
                check("rnd_key", core_key, key_model);
            end
            send_block({$urandom, $urandom, $urandom, $urandom});
            if ($urandom_range(0, 1) == 1) send_block({$urandom, $urandom, $urandom, $urandom});
            wait_drain("rnd");
        end
        check("final_out_queue_empty", exp_out.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
